// File: rtl/setclr_pkg.sv
// setclr_pkg: shared FSM encoding, default sizes and helpers for the set/clear pulse generator
package setclr_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_t;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_GAP = 3;
    localparam int GAP_W = 4;
    localparam int SKIP_W = 8;
    function automatic logic [SKIP_W-1:0] sat_inc(input logic [SKIP_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/setclr_pulse_gen_if.sv
// setclr_pulse_gen_if: command handshake and latch-drive signals of the pulse generator
interface setclr_pulse_gen_if;
    import setclr_pkg::*;
    logic cmd_valid;
    logic cmd_level;
    logic cmd_ready;
    logic set_o;
    logic clr_o;
    logic level_o;
    logic busy;
    logic [SKIP_W-1:0] skip_cnt;
    modport master(
        output cmd_valid, cmd_level,
        input cmd_ready, set_o, clr_o, level_o, busy, skip_cnt
    );
    modport slave(
        input cmd_valid, cmd_level,
        output cmd_ready, set_o, clr_o, level_o, busy, skip_cnt
    );
endinterface

// File: rtl/setclr_fifo.sv
// setclr_fifo: 1-bit command FIFO with wrap-bit pointers for full/empty distinction
module setclr_fifo #(
    parameter int DEPTH = setclr_pkg::DEF_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic pop_data,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem;
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop_data = mem[rp[AW-1:0]];
    // Pointer update; push and pop in the same cycle both advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    // Storage needs no reset: empty pointers hide stale contents
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/setclr_pulse_gen.sv
// setclr_pulse_gen: turns queued level commands into spaced one-cycle set/clear pulses
module setclr_pulse_gen
    import setclr_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int GAP = DEF_GAP
) (
    input logic clk,
    input logic reset,
    setclr_pulse_gen_if.slave bus
);
    state_t state, state_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [SKIP_W-1:0] skip_q, skip_n;
    logic set_q, set_n, clr_q, clr_n, level_q, level_n;
    logic pop, head, full, empty;
    setclr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(bus.cmd_valid && !full),
        .push_data(bus.cmd_level),
        .pop(pop),
        .pop_data(head),
        .full(full),
        .empty(empty)
    );
    assign bus.cmd_ready = !full;
    assign bus.set_o = set_q;
    assign bus.clr_o = clr_q;
    assign bus.level_o = level_q;
    assign bus.skip_cnt = skip_q;
    assign bus.busy = !empty || state != ST_IDLE;
    // Next state: pop only in IDLE; redundant heads are dropped and counted, the rest pulse
    always_comb begin
        state_n = state;
        gap_n = gap_cnt;
        set_n = 1'b0;
        clr_n = 1'b0;
        level_n = level_q;
        skip_n = skip_q;
        pop = 1'b0;
        case (state)
            ST_IDLE: begin
                gap_n = '0;
                if (!empty) begin
                    pop = 1'b1;
                    if (head != level_q) begin
                        state_n = ST_PULSE;
                        set_n = head;
                        clr_n = !head;
                        level_n = head;
                    end else begin
                        skip_n = sat_inc(skip_q);
                    end
                end
            end
            ST_PULSE: begin
                state_n = ST_GAP;
                gap_n = GAP_W'(GAP);
            end
            ST_GAP: begin
                gap_n = gap_cnt - 1'b1;
                state_n = gap_cnt <= GAP_W'(2) ? ST_IDLE : ST_GAP;
            end
            default: state_n = ST_IDLE;
        endcase
    end
    // State register; reset discards everything and drops the outputs at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            gap_cnt <= '0;
            set_q <= 1'b0;
            clr_q <= 1'b0;
            level_q <= 1'b0;
            skip_q <= '0;
        end else begin
            state <= state_n;
            gap_cnt <= gap_n;
            set_q <= set_n;
            clr_q <= clr_n;
            level_q <= level_n;
            skip_q <= skip_n;
        end
    end
endmodule

// File: tb/tb_setclr_pulse_gen.sv
// tb_setclr_pulse_gen: directed self-checking bench for setclr_pulse_gen
module tb_setclr_pulse_gen;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    int pulse_total = 0;
    logic latch_q;
    logic latch_d;
    setclr_pulse_gen_if bus();
    setclr_pulse_gen #(.DEPTH(4), .GAP(3)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (bus.set_o || bus.clr_o) pulse_total++;
    assign latch_d = bus.set_o ? 1'b1 : bus.clr_o ? 1'b0 : latch_q;
    always @(posedge clk or posedge reset) latch_q <= reset ? 1'b0 : latch_d;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        bus.cmd_valid = 1'b0;
        bus.cmd_level = 1'b0;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        bus.cmd_valid = 1'b0;
        bus.cmd_level = 1'b0;
        reset = 1'b1;
        #2;
        checks++;
        if ({bus.set_o, bus.clr_o, bus.level_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses got %b exp 000", {bus.set_o, bus.clr_o, bus.level_o});
        end
        checks++;
        if (bus.skip_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_skip got %0d exp 0", bus.skip_cnt);
        end
        checks++;
        if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_ready_busy got %b exp 10", {bus.cmd_ready, bus.busy});
        end
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_first_set;
        bus.cmd_valid = 1'b1;
        bus.cmd_level = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.set_o, bus.clr_o, bus.busy} !== 3'b001) begin
            errors++;
            $display("FAIL first_k got %b exp 001", {bus.set_o, bus.clr_o, bus.busy});
        end
        tick;
        checks++;
        if ({bus.set_o, bus.clr_o, bus.level_o} !== 3'b101) begin
            errors++;
            $display("FAIL first_k1 got %b exp 101", {bus.set_o, bus.clr_o, bus.level_o});
        end
        tick;
        checks++;
        if ({bus.set_o, bus.clr_o, bus.level_o} !== 3'b001) begin
            errors++;
            $display("FAIL first_k2 got %b exp 001", {bus.set_o, bus.clr_o, bus.level_o});
        end
        repeat (3) tick;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL first_idle busy got %b exp 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_v;
        apply_reset;
        bus.cmd_valid = 1'b1;
        bus.cmd_level = 1'b1;
        for (int e = 0; e < 14; e++) begin
            tick;
            if (e == 0) bus.cmd_level = 1'b0;
            else if (e == 1) bus.cmd_level = 1'b1;
            else if (e == 2) bus.cmd_valid = 1'b0;
            exp_v = {e == 1 || e == 9, e == 5, (e >= 1 && e <= 4) || e >= 9, e < 12};
            checks++;
            if ({bus.set_o, bus.clr_o, bus.level_o, bus.busy} !== exp_v) begin
                errors++;
                $display("FAIL b2b e=%0d set/clr/level/busy got %b exp %b", e,
                         {bus.set_o, bus.clr_o, bus.level_o, bus.busy}, exp_v);
            end
        end
    endtask

    task automatic test_skip;
        int base;
        apply_reset;
        base = pulse_total;
        bus.cmd_valid = 1'b1;
        bus.cmd_level = 1'b0;
        tick;
        bus.cmd_valid = 1'b0;
        tick;
        tick;
        checks++;
        if (bus.skip_cnt !== 8'd1) begin
            errors++;
            $display("FAIL skip_one got %0d exp 1", bus.skip_cnt);
        end
        bus.cmd_valid = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            tick;
            if (n == 100) begin
                checks++;
                if (bus.skip_cnt !== 8'd100) begin
                    errors++;
                    $display("FAIL skip_100 got %0d exp 100", bus.skip_cnt);
                end
            end
        end
        bus.cmd_valid = 1'b0;
        repeat (4) tick;
        checks++;
        if (bus.skip_cnt !== 8'd255) begin
            errors++;
            $display("FAIL skip_sat got %0d exp 255", bus.skip_cnt);
        end
        checks++;
        if (pulse_total - base !== 0 || bus.level_o !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL skip_nopulse pulses %0d level %b busy %b exp 0 0 0",
                     pulse_total - base, bus.level_o, bus.busy);
        end
    endtask

    task automatic test_backpressure;
        int base;
        int acc;
        int first_stall;
        int cyc;
        apply_reset;
        base = pulse_total;
        bus.cmd_valid = 1'b1;
        bus.cmd_level = 1'b1;
        acc = 0;
        first_stall = -1;
        cyc = 0;
        while (acc < 12 && cyc < 300) begin
            if (bus.cmd_ready) begin
                tick;
                acc++;
                bus.cmd_level = ~bus.cmd_level;
            end else begin
                if (first_stall < 0) first_stall = acc;
                tick;
            end
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (first_stall !== 5) begin
            errors++;
            $display("FAIL bp_stall accepts before stall got %0d exp 5", first_stall);
        end
        checks++;
        if (acc !== 12) begin
            errors++;
            $display("FAIL bp_accepts got %0d exp 12", acc);
        end
        for (int i = 0; i < 200 && bus.busy; i++) tick;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain busy got %b exp 0", bus.busy);
        end
        checks++;
        if (pulse_total - base !== 12) begin
            errors++;
            $display("FAIL bp_pulses got %0d exp 12", pulse_total - base);
        end
    endtask

    task automatic test_reset_mid_gap;
        int base;
        apply_reset;
        bus.cmd_valid = 1'b1;
        bus.cmd_level = 1'b1;
        tick;
        bus.cmd_level = 1'b0;
        tick;
        checks++;
        if (bus.set_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_set got %b exp 1", bus.set_o);
        end
        bus.cmd_level = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        tick;
        checks++;
        if ({bus.busy, bus.level_o} !== 2'b11) begin
            errors++;
            $display("FAIL mid_gap busy/level got %b exp 11", {bus.busy, bus.level_o});
        end
        base = pulse_total;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({bus.set_o, bus.clr_o, bus.level_o, bus.cmd_ready, bus.busy} !== 5'b00010 ||
            bus.skip_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset set/clr/level/ready/busy got %b skip %0d exp 00010 0",
                     {bus.set_o, bus.clr_o, bus.level_o, bus.cmd_ready, bus.busy}, bus.skip_cnt);
        end
        tick;
        reset = 1'b0;
        repeat (20) tick;
        checks++;
        if (pulse_total - base !== 0 || bus.level_o !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after pulses %0d level %b busy %b exp 0 0 0",
                     pulse_total - base, bus.level_o, bus.busy);
        end
    endtask

    task automatic test_latch_model;
        logic [31:0] vpat;
        logic [31:0] lpat;
        apply_reset;
        vpat = 32'hB5E3_96C7;
        lpat = 32'h6A3C_F10D;
        for (int c = 0; c < 60; c++) begin
            bus.cmd_valid = vpat[c % 32];
            bus.cmd_level = lpat[(c * 7) % 32];
            tick;
            checks++;
            if (latch_d !== bus.level_o) begin
                errors++;
                $display("FAIL latch c=%0d latch got %b level_o %b", c, latch_d, bus.level_o);
            end
            checks++;
            if (bus.set_o && bus.clr_o) begin
                errors++;
                $display("FAIL excl c=%0d set/clr got 11 exp not both", c);
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_first_set;
        test_back_to_back;
        test_skip;
        test_backpressure;
        test_reset_mid_gap;
        test_latch_model;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
